except_ctrl: RTL and testbench
==============================

EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC0_0380, exception entry address.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wb_except  in  1  writeback-stage instruction carries an exception.
REQ-005 SHALL have port wb_excode  in  5  ExcCode of that exception (00 Int, 04 AdEL, 05 AdES, 08 Sys, 09 Bp, 0A RI, 0C Ov).
REQ-006 SHALL have port wb_pc  in  32  PC of writeback instruction.
REQ-007 SHALL have port wb_bd  in  1  writeback instruction is in a delay slot.
REQ-008 SHALL have port wb_badvaddr  in  32  faulting address for AdEL/AdES.
REQ-009 SHALL have port wb_eret  in  1  writeback instruction is ERET.
REQ-010 SHALL have port ext_int  in  6  hardware interrupt lines, level-sensitive.
REQ-011 SHALL have ports mtc0_we  in  1, c0_addr  in  5, mtc0_wdata  in  32  CP0 write (BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14).
REQ-012 SHALL have port mfc0_rdata  out  32  combinational read of register at c0_addr; unmapped returns 0.
REQ-013 SHALL have port flush  out  1  kill all pipeline stages.
REQ-014 SHALL have ports redirect_valid  out  1, redirect_pc  out  32, redirect_ready  in  1  fetch redirect handshake.
REQ-015 SHALL have port int_pending  out  1  interrupt to be tagged onto next instruction by decode.

Function
REQ-016 FSM states IDLE, FLUSH, REDIRECT; reset state IDLE.
REQ-017 IDLE with wb_except=1: in same edge update CP0 (REQ-020), go FLUSH.
REQ-018 IDLE with wb_eret=1 and wb_except=0: clear Status.EXL, target=EPC, go FLUSH.
REQ-019 wb_except and wb_eret together: exception wins, ERET ignored.
REQ-020 Exception update: Cause.ExcCode=wb_excode; Cause.BD=wb_bd; EPC=wb_bd ? wb_pc-4 : wb_pc; Status.EXL=1; BadVAddr=wb_badvaddr only for excode 04/05; target=EXC_VECTOR.
REQ-021 If Status.EXL already 1 on exception: EPC and Cause.BD unchanged, other updates apply.
REQ-022 FLUSH: flush=1 for exactly one cycle, then REDIRECT.
REQ-023 REDIRECT: redirect_valid=1, redirect_pc=latched target held stable; on redirect_valid&&redirect_ready go IDLE next edge.
REQ-024 wb_except/wb_eret ignored in FLUSH and REDIRECT (pipeline already killed).
REQ-025 Minimum event-to-IDLE latency 3 cycles (capture, FLUSH, REDIRECT with ready=1).
REQ-026 Count increments by 1 every second cycle (internal toggle), wraps 32'hFFFF_FFFF to 0.
REQ-027 Count==Compare (after increment) sets Cause.TI; mtc0 to Compare clears TI.
REQ-028 Cause.IP[7:2] = {ext_int[5]|TI, ext_int[4:0]} sampled every cycle; IP[1:0] software-writable.
REQ-029 int_pending = |(Cause.IP & Status.IM) && Status.IE && !Status.EXL && state==IDLE.
REQ-030 mtc0 writable fields only: Status.IM/EXL/IE, Cause.IP[1:0], EPC, Count, Compare; others read-only.
REQ-031 Same-edge mtc0 and exception/ERET: hardware update wins on overlapping fields; mtc0 to Count wins over increment.
REQ-032 mfc0_rdata reflects state before current edge (no bypass).

Reset
REQ-033 resetn=0 asynchronously: state IDLE, flush=0, redirect_valid=0, redirect_pc=0, int_pending=0.
REQ-034 Reset values: Status=32'h0040_0000 (BEV=1, EXL=0, IE=0, IM=0), Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, tick toggle=0.
REQ-035 Reset mid-REDIRECT abandons handshake; no redirect after release.

Structure
REQ-036 Shared package cpu_pkg SHALL hold ExcCode constants, CP0 register addresses, FSM state enum, EXC_VECTOR default.
REQ-037 One sub-module cp0_timer (Count, Compare, tick toggle, TI) SHALL be instantiated; remainder flat.

Verification
REQ-038 Ov (0C) at wb_pc=0x8000_0100, bd=0 -> EPC=0x8000_0100, ExcCode=0C, EXL=1, flush 1 cycle, redirect_pc=0xBFC0_0380.
REQ-039 AdEL in delay slot, wb_pc=0x8000_0204, badvaddr=0x1003 -> EPC=0x8000_0200, BD=1, BadVAddr=0x1003.
REQ-040 ERET with EPC=0x8000_0040, redirect_ready low 4 cycles -> redirect_valid held 4 cycles, pc stable, EXL=0 after.
REQ-041 Compare=10, Status IE=1 IM[7]=1 -> int_pending rises when Count hits 10 (~cycle 20); mtc0 Compare clears it.
REQ-042 wb_except and wb_eret same cycle, plus second wb_except during FLUSH -> only first exception recorded.
REQ-043 resetn low during REDIRECT -> all outputs 0 immediately, Status=0x0040_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, CP0 register numbers, exception
// FSM states and the default exception entry address.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

   // ExcCode values carried into Cause.ExcCode
   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0A;
   localparam logic [4:0] EXC_OV   = 5'h0C;

   // CP0 register numbers
   localparam logic [4:0] C0_BADVADDR = 5'd8;
   localparam logic [4:0] C0_COUNT    = 5'd9;
   localparam logic [4:0] C0_COMPARE  = 5'd11;
   localparam logic [4:0] C0_STATUS   = 5'd12;
   localparam logic [4:0] C0_CAUSE    = 5'd13;
   localparam logic [4:0] C0_EPC      = 5'd14;

   // Exception sequencing states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_e;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer.
//   clk, resetn         : clock, async active-low reset
//   count_we/compare_we : software write strobes, data on wdata
//   count, compare      : current register values
//   ti                  : timer interrupt flag (Count reached Compare)
module cp0_timer (
   input  logic        clk,
   input  logic        resetn,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic        tick;
   logic [31:0] count_inc;

   assign count_inc = count + 32'd1;

   // Count advances on every other cycle; a software write overrides the step
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tick    <= 1'b0;
         count   <= '0;
         compare <= '0;
         ti      <= 1'b0;
      end else begin
         tick <= ~tick;
         if (count_we)
            count <= wdata;
         else if (tick)
            count <= count_inc;
         if (compare_we)
            compare <= wdata;
         // Writing Compare acknowledges the timer interrupt
         if (compare_we)
            ti <= 1'b0;
         else if (!count_we && tick && (count_inc == compare))
            ti <= 1'b1;
      end
   end

endmodule

// File: rtl/except_ctrl.sv
// Exception / ERET controller with the CP0 status registers.
//   clk, resetn                    : clock, async active-low reset
//   wb_*                           : writeback-stage exception / ERET info
//   ext_int                        : level-sensitive hardware interrupts
//   mtc0_we, c0_addr, mtc0_wdata   : CP0 write port (c0_addr also selects read)
//   mfc0_rdata                     : combinational CP0 read
//   flush                          : one-cycle pipeline kill
//   redirect_valid/pc/ready        : fetch redirect handshake
//   int_pending                    : interrupt request for decode
module except_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_except,
   input  logic [4:0]  wb_excode,
   input  logic [31:0] wb_pc,
   input  logic        wb_bd,
   input  logic [31:0] wb_badvaddr,
   input  logic        wb_eret,
   input  logic [5:0]  ext_int,
   input  logic        mtc0_we,
   input  logic [4:0]  c0_addr,
   input  logic [31:0] mtc0_wdata,
   output logic [31:0] mfc0_rdata,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        int_pending
);

   state_e      state, state_nx;
   logic        flush_nx, redirect_valid_nx;
   logic [31:0] redirect_pc_nx;
   logic        exc_take, eret_take;

   logic [31:0] target_q;
   logic [7:0]  status_im;
   logic        status_exl, status_ie;
   logic        cause_bd;
   logic [4:0]  cause_excode;
   logic [5:0]  ip_hw;
   logic [1:0]  ip_sw;
   logic [31:0] epc, badvaddr;
   logic [31:0] count, compare;
   logic        ti;
   logic        status_we, cause_we, epc_we, count_we, compare_we;
   logic [31:0] status_rd, cause_rd;

   assign status_we  = mtc0_we && (c0_addr == C0_STATUS);
   assign cause_we   = mtc0_we && (c0_addr == C0_CAUSE);
   assign epc_we     = mtc0_we && (c0_addr == C0_EPC);
   assign count_we   = mtc0_we && (c0_addr == C0_COUNT);
   assign compare_we = mtc0_we && (c0_addr == C0_COMPARE);

   cp0_timer u_timer (
      .clk        (clk),
      .resetn     (resetn),
      .count_we   (count_we),
      .compare_we (compare_we),
      .wdata      (mtc0_wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   // State register and registered handshake outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= ST_IDLE;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         state          <= state_nx;
         flush          <= flush_nx;
         redirect_valid <= redirect_valid_nx;
         redirect_pc    <= redirect_pc_nx;
      end
   end

   // Next state; events are only accepted in IDLE, exception beats ERET
   always_comb begin
      state_nx  = state;
      exc_take  = 1'b0;
      eret_take = 1'b0;
      case (state)
         ST_IDLE: begin
            if (wb_except) begin
               exc_take = 1'b1;
               state_nx = ST_FLUSH;
            end else if (wb_eret) begin
               eret_take = 1'b1;
               state_nx  = ST_FLUSH;
            end
         end
         ST_FLUSH:    state_nx = ST_REDIRECT;
         ST_REDIRECT: if (redirect_valid && redirect_ready) state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
      flush_nx          = (state_nx == ST_FLUSH);
      redirect_valid_nx = (state_nx == ST_REDIRECT);
      redirect_pc_nx    = redirect_valid_nx ? target_q : 32'd0;
   end

   // CP0 Status/Cause/EPC/BadVAddr; hardware updates override mtc0 per field
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         target_q     <= '0;
         status_im    <= '0;
         status_exl   <= 1'b0;
         status_ie    <= 1'b0;
         cause_bd     <= 1'b0;
         cause_excode <= '0;
         ip_hw        <= '0;
         ip_sw        <= '0;
         epc          <= '0;
         badvaddr     <= '0;
      end else begin
         ip_hw <= {ext_int[5] | ti, ext_int[4:0]};
         if (cause_we)
            ip_sw <= mtc0_wdata[9:8];
         if (status_we) begin
            status_im <= mtc0_wdata[15:8];
            status_ie <= mtc0_wdata[0];
         end

         if (exc_take)
            status_exl <= 1'b1;
         else if (eret_take)
            status_exl <= 1'b0;
         else if (status_we)
            status_exl <= mtc0_wdata[1];

         if (exc_take)
            target_q <= EXC_VECTOR;
         else if (eret_take)
            target_q <= epc;

         if (exc_take) begin
            cause_excode <= wb_excode;
            if (wb_excode == EXC_ADEL || wb_excode == EXC_ADES)
               badvaddr <= wb_badvaddr;
         end

         // A nested exception (EXL already set) keeps the original EPC/BD
         if (exc_take && !status_exl) begin
            cause_bd <= wb_bd;
            epc      <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
         end else if (epc_we) begin
            epc <= mtc0_wdata;
         end
      end
   end

   assign status_rd = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
   assign cause_rd  = {cause_bd, ti, 14'd0, ip_hw, ip_sw, 1'b0, cause_excode, 2'd0};

   // Register read, no bypass of same-cycle writes
   always_comb begin
      mfc0_rdata = '0;
      case (c0_addr)
         C0_BADVADDR: mfc0_rdata = badvaddr;
         C0_COUNT:    mfc0_rdata = count;
         C0_COMPARE:  mfc0_rdata = compare;
         C0_STATUS:   mfc0_rdata = status_rd;
         C0_CAUSE:    mfc0_rdata = cause_rd;
         C0_EPC:      mfc0_rdata = epc;
         default:     mfc0_rdata = '0;
      endcase
   end

   assign int_pending = (|({ip_hw, ip_sw} & status_im)) && status_ie &&
                        !status_exl && (state == ST_IDLE);

endmodule

// File: tb/tb_except_ctrl.sv
module tb_except_ctrl;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        wb_except, wb_bd, wb_eret, mtc0_we, redirect_ready;
   logic [4:0]  wb_excode, c0_addr;
   logic [31:0] wb_pc, wb_badvaddr, mtc0_wdata;
   logic [5:0]  ext_int;
   logic [31:0] mfc0_rdata, redirect_pc;
   logic        flush, redirect_valid, int_pending;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   except_ctrl dut (
      .clk            (clk),
      .resetn         (resetn),
      .wb_except      (wb_except),
      .wb_excode      (wb_excode),
      .wb_pc          (wb_pc),
      .wb_bd          (wb_bd),
      .wb_badvaddr    (wb_badvaddr),
      .wb_eret        (wb_eret),
      .ext_int        (ext_int),
      .mtc0_we        (mtc0_we),
      .c0_addr        (c0_addr),
      .mtc0_wdata     (mtc0_wdata),
      .mfc0_rdata     (mfc0_rdata),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
      .int_pending    (int_pending)
   );

   typedef struct {
      logic [4:0]  code;
      logic [31:0] pc;
      logic        bd;
      logic [31:0] badv;
      logic [31:0] exp_epc;
      logic [31:0] exp_cause;
      logic [31:0] exp_badv;
   } vec_t;

   vec_t vt [6];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      c0_addr = a;
      #1;
      d = mfc0_rdata;
   endtask

   // Called at a negedge; returns at a later negedge with the write applied
   task automatic mtc(input logic [4:0] a, input logic [31:0] d);
      mtc0_we    = 1'b1;
      c0_addr    = a;
      mtc0_wdata = d;
      @(posedge clk);
      @(negedge clk);
      mtc0_we = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [31:0] d;
   int          waited;

   initial begin
      resetn = 1'b0; wb_except = 0; wb_excode = '0; wb_pc = '0; wb_bd = 0;
      wb_badvaddr = '0; wb_eret = 0; ext_int = '0; mtc0_we = 0; c0_addr = '0;
      mtc0_wdata = '0; redirect_ready = 0;

      vt[0] = '{5'h0C, 32'h8000_0100, 1'b0, 32'hDEAD_BEEF, 32'h8000_0100, 32'h0000_0030, 32'h0000_0000};
      vt[1] = '{5'h04, 32'h8000_0204, 1'b1, 32'h0000_1003, 32'h8000_0200, 32'h8000_0010, 32'h0000_1003};
      vt[2] = '{5'h05, 32'h8000_1000, 1'b0, 32'h2222_0001, 32'h8000_1000, 32'h0000_0014, 32'h2222_0001};
      vt[3] = '{5'h08, 32'h0040_0010, 1'b0, 32'h0000_5555, 32'h0040_0010, 32'h0000_0020, 32'h2222_0001};
      vt[4] = '{5'h09, 32'h0040_0020, 1'b1, 32'h0000_7777, 32'h0040_001C, 32'h8000_0024, 32'h2222_0001};
      vt[5] = '{5'h0A, 32'h0000_0000, 1'b1, 32'h0000_8888, 32'hFFFF_FFFC, 32'h8000_0028, 32'h2222_0001};

      @(negedge clk);
      @(negedge clk);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_rv", 32'(redirect_valid), 32'd0);
      chk("rst_rpc", redirect_pc, 32'd0);
      chk("rst_intp", 32'(int_pending), 32'd0);
      rd(C0_STATUS, d); chk("rst_status", d, 32'h0040_0000);
      rd(C0_CAUSE, d);  chk("rst_cause", d, 32'd0);
      rd(C0_EPC, d);    chk("rst_epc", d, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Exception table
      for (int i = 0; i < 6; i++) begin
         mtc(C0_STATUS, 32'd0);
         wb_except = 1; wb_excode = vt[i].code; wb_pc = vt[i].pc;
         wb_bd = vt[i].bd; wb_badvaddr = vt[i].badv;
         cyc();
         wb_except = 0;
         chk($sformatf("v%0d_flush", i), 32'(flush), 32'd1);
         chk($sformatf("v%0d_rv0", i), 32'(redirect_valid), 32'd0);
         cyc();
         chk($sformatf("v%0d_flush_off", i), 32'(flush), 32'd0);
         chk($sformatf("v%0d_rv", i), 32'(redirect_valid), 32'd1);
         chk($sformatf("v%0d_rpc", i), redirect_pc, 32'hBFC0_0380);
         redirect_ready = 1;
         cyc();
         redirect_ready = 0;
         chk($sformatf("v%0d_rv_done", i), 32'(redirect_valid), 32'd0);
         rd(C0_EPC, d);      chk($sformatf("v%0d_epc", i), d, vt[i].exp_epc);
         rd(C0_CAUSE, d);    chk($sformatf("v%0d_cause", i), d, vt[i].exp_cause);
         rd(C0_BADVADDR, d); chk($sformatf("v%0d_badv", i), d, vt[i].exp_badv);
         rd(C0_STATUS, d);   chk($sformatf("v%0d_status", i), d, 32'h0040_0002);
      end

      // ERET with fetch stalling for 4 cycles
      mtc(C0_EPC, 32'h8000_0040);
      wb_eret = 1;
      cyc();
      wb_eret = 0;
      chk("eret_flush", 32'(flush), 32'd1);
      cyc();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("eret_rv%0d", k), 32'(redirect_valid), 32'd1);
         chk($sformatf("eret_rpc%0d", k), redirect_pc, 32'h8000_0040);
         cyc();
      end
      redirect_ready = 1;
      cyc();
      redirect_ready = 0;
      chk("eret_done", 32'(redirect_valid), 32'd0);
      rd(C0_STATUS, d); chk("eret_exl", d, 32'h0040_0000);

      // Exception + ERET together, second exception during FLUSH
      wb_except = 1; wb_eret = 1; wb_excode = 5'h0C; wb_pc = 32'h8000_0300;
      wb_bd = 0; wb_badvaddr = 32'h0000_0ABC;
      cyc();
      wb_eret = 0; wb_excode = 5'h04; wb_pc = 32'h9000_0000; wb_bd = 1;
      wb_badvaddr = 32'h0000_4444;
      chk("dual_flush", 32'(flush), 32'd1);
      cyc();
      wb_except = 0;
      chk("dual_rpc", redirect_pc, 32'hBFC0_0380);
      redirect_ready = 1;
      cyc();
      redirect_ready = 0;
      rd(C0_EPC, d);      chk("dual_epc", d, 32'h8000_0300);
      rd(C0_CAUSE, d);    chk("dual_cause", d, 32'h0000_0030);
      rd(C0_BADVADDR, d); chk("dual_badv", d, 32'h2222_0001);
      rd(C0_STATUS, d);   chk("dual_status", d, 32'h0040_0002);

      // Timer interrupt
      mtc(C0_STATUS, 32'h0000_8001);
      mtc(C0_COMPARE, 32'd10);
      mtc(C0_COUNT, 32'd0);
      waited = 1;
      while (!int_pending && waited < 40) begin
         cyc();
         waited++;
      end
      chk("ti_seen", 32'(int_pending), 32'd1);
      checks++;
      if (waited < 20 || waited > 21) begin
         errors++;
         $display("FAIL ti_latency: got %0d cycles expected 20..21", waited);
      end
      rd(C0_COUNT, d); chk("ti_count", d, 32'd10);
      rd(C0_CAUSE, d); chk("ti_cause", d & 32'h4000_8000, 32'h4000_8000);
      mtc(C0_COMPARE, 32'd100);
      cyc();
      chk("ti_clear", 32'(int_pending), 32'd0);
      rd(C0_CAUSE, d); chk("ti_cause_clr", d & 32'h4000_8000, 32'd0);

      // Reset while waiting in REDIRECT
      wb_except = 1; wb_excode = 5'h0C; wb_pc = 32'h8000_0500; wb_bd = 0;
      cyc();
      wb_except = 0;
      cyc();
      chk("rr_rv", 32'(redirect_valid), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("rr_rv0", 32'(redirect_valid), 32'd0);
      chk("rr_rpc0", redirect_pc, 32'd0);
      chk("rr_flush0", 32'(flush), 32'd0);
      chk("rr_intp0", 32'(int_pending), 32'd0);
      rd(C0_STATUS, d); chk("rr_status", d, 32'h0040_0000);
      rd(C0_COUNT, d);  chk("rr_count", d, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      redirect_ready = 1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("rr_idle%0d", k), 32'(redirect_valid), 32'd0);
      end
      redirect_ready = 0;

      // Writable-field masking and software interrupts
      mtc(C0_CAUSE, 32'hFFFF_FFFF);
      rd(C0_CAUSE, d);    chk("sw_cause", d, 32'h0000_0300);
      mtc(C0_BADVADDR, 32'h0000_FFFF);
      rd(C0_BADVADDR, d); chk("ro_badv", d, 32'd0);
      rd(5'd0, d);        chk("unmapped", d, 32'd0);
      mtc(C0_STATUS, 32'hFFFF_FFFF);
      rd(C0_STATUS, d);   chk("status_mask", d, 32'h0040_FF03);
      chk("sw_exl_mask", 32'(int_pending), 32'd0);
      mtc(C0_STATUS, 32'h0000_0101);
      chk("sw_int", 32'(int_pending), 32'd1);
      mtc(C0_STATUS, 32'h0000_0201);
      chk("sw_im_mask", 32'(int_pending), 32'd1);
      mtc(C0_STATUS, 32'h0000_0100);
      chk("sw_ie_mask", 32'(int_pending), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
